// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch memory: response error codes
// and the default instruction returned on an erroneous fetch.
package imem_pkg;

    typedef enum logic [1:0] {
        ERR_OK           = 2'd0,
        ERR_MISALIGNED   = 2'd1,
        ERR_OUT_OF_RANGE = 2'd2
    } imem_err_e;

    localparam logic [63:0] DEFAULT_NOP = '0;

    localparam int unsigned COUNT_W = 16;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W instruction store with one synchronous write port and one
// synchronous read port. The read register only updates on rd_en, so the last
// word read is held for as long as the consumer needs it.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Program-load write; contents are never reset, indices past DEPTH are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_idx) < 32'(DEPTH))) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Registered read, cleared by reset so the response word reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/instruction_fetch_memory.sv
// Instruction fetch memory: valid/ready fetch port with one-cycle response
// latency, alignment and range checking, flush, program-load port and a
// saturating count of consumed responses.
module instruction_fetch_memory
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEFAULT_NOP)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_instr,
    output logic [1:0]               resp_err,
    input  logic                     flush,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [DATA_W-1:0]        load_data,
    output logic [COUNT_W-1:0]       fetch_count
);

    localparam int unsigned        IDX_W    = $clog2(DEPTH);
    localparam int unsigned        OFF_W    = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0]  OFF_MASK = ADDR_W'((DATA_W / 8) - 1);
    localparam logic [ADDR_W-1:0]  DEPTH_A  = ADDR_W'(DEPTH);

    logic [ADDR_W-1:0]  word_idx;
    imem_err_e          fetch_err;
    imem_err_e          err_q;
    logic               valid_q;
    logic [COUNT_W-1:0] count_q;
    logic [DATA_W-1:0]  rd_data;
    logic               accept;
    logic               consume;
    logic               rd_en;

    assign word_idx    = fetch_addr >> OFF_W;
    assign fetch_ready = !load_en && !flush && (!valid_q || resp_ready);
    assign accept      = fetch_valid && fetch_ready;
    assign consume     = valid_q && resp_ready && !flush;
    assign rd_en       = accept && (fetch_err == ERR_OK);

    // Classify the incoming address; misalignment wins over out-of-range.
    always_comb begin
        fetch_err = ERR_OK;
        if ((fetch_addr & OFF_MASK) != '0) begin
            fetch_err = ERR_MISALIGNED;
        end else if (word_idx >= DEPTH_A) begin
            fetch_err = ERR_OUT_OF_RANGE;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (load_en),
        .wr_idx  (load_idx),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_idx  (word_idx[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    // Response valid/error register: flush drops, accept loads, consume clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            err_q   <= ERR_OK;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            err_q   <= fetch_err;
        end else if (resp_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Saturating count of responses taken by the consumer outside flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (consume && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign resp_valid  = valid_q;
    assign resp_err    = err_q;
    assign resp_instr  = (err_q == ERR_OK) ? rd_data : NOP_WORD;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed self-checking bench for instruction_fetch_memory.
module tb_instruction_fetch_memory;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 64;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [1:0]  resp_err;
    logic        flush;
    logic        load_en;
    logic [5:0]  load_idx;
    logic [31:0] load_data;
    logic [15:0] fetch_count;

    logic [31:0] model [DEPTH];
    logic [15:0] exp_count;
    int          n_checks;
    int          n_fail;

    instruction_fetch_memory #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_addr  (fetch_addr),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_instr  (resp_instr),
        .resp_err    (resp_err),
        .flush       (flush),
        .load_en     (load_en),
        .load_idx    (load_idx),
        .load_data   (load_data),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [5:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = data;
        tick();
        load_en   = 1'b0;
        model[idx] = data;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
        n_checks++; if (resp_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", resp_instr); end
        n_checks++; if (resp_err !== 2'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", resp_err); end
        n_checks++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", fetch_ready); end
    endtask

    task automatic test_basic();
        resp_ready  = 1'b1;
        fetch_valid = 1'b1;
        fetch_addr  = 32'h8;
        #1;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b expected 1", fetch_ready); end
        tick();
        fetch_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", resp_valid); end
        n_checks++; if (resp_instr !== 32'hAD29_0000) begin n_fail++; $display("FAIL basic_instr: got %h expected ad290000", resp_instr); end
        n_checks++; if (resp_err !== 2'd0) begin n_fail++; $display("FAIL basic_err: got %0d expected 0", resp_err); end
        tick();
        exp_count = 16'd1;
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", fetch_count, exp_count); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got %b expected 0", resp_valid); end
    endtask

    task automatic test_streaming();
        resp_ready  = 1'b1;
        fetch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 32'(i * 4);
            #1;
            n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, fetch_ready); end
            tick();
            n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, resp_valid); end
            n_checks++; if (resp_instr !== model[i]) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, resp_instr, model[i]); end
        end
        fetch_valid = 1'b0;
        tick();
        exp_count = exp_count + 16'd3;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drop: got %b expected 0", resp_valid); end
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL stream_count: got %0d expected %0d", fetch_count, exp_count); end
    endtask

    task automatic test_backpressure();
        resp_ready  = 1'b0;
        fetch_valid = 1'b1;
        fetch_addr  = 32'hC;
        tick();
        fetch_addr  = 32'h10;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, fetch_ready); end
            n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid); end
            n_checks++; if (resp_instr !== model[3]) begin n_fail++; $display("FAIL bp_instr[%0d]: got %h expected %h", i, resp_instr, model[3]); end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", fetch_ready); end
        tick();
        fetch_valid = 1'b0;
        exp_count = exp_count + 16'd1;
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b expected 1", resp_valid); end
        n_checks++; if (resp_instr !== model[4]) begin n_fail++; $display("FAIL bp_next_instr: got %h expected %h", resp_instr, model[4]); end
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", fetch_count, exp_count); end
        tick();
        exp_count = exp_count + 16'd1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: got %b expected 0", resp_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic [1:0]  errs  [4];
        logic [31:0] instrs[4];
        addrs[0] = 32'h6;   errs[0] = 2'd1; instrs[0] = NOP;
        addrs[1] = 32'h100; errs[1] = 2'd2; instrs[1] = NOP;
        addrs[2] = 32'hFC;  errs[2] = 2'd0; instrs[2] = model[63];
        addrs[3] = 32'h102; errs[3] = 2'd1; instrs[3] = NOP;
        resp_ready  = 1'b1;
        fetch_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_addr = addrs[i];
            tick();
            n_checks++; if (resp_err !== errs[i]) begin n_fail++; $display("FAIL err_code[%h]: got %0d expected %0d", addrs[i], resp_err, errs[i]); end
            n_checks++; if (resp_instr !== instrs[i]) begin n_fail++; $display("FAIL err_instr[%h]: got %h expected %h", addrs[i], resp_instr, instrs[i]); end
        end
        fetch_valid = 1'b0;
        tick();
        exp_count = exp_count + 16'd4;
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL err_count: got %0d expected %0d", fetch_count, exp_count); end
    endtask

    task automatic test_flush();
        resp_ready  = 1'b0;
        fetch_valid = 1'b1;
        fetch_addr  = 32'h8;
        tick();
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pending: got %b expected 1", resp_valid); end
        fetch_addr = 32'h0;
        flush      = 1'b1;
        resp_ready = 1'b1;
        #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", fetch_ready); end
        tick();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", resp_valid); end
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL flush_count: got %0d expected %0d", fetch_count, exp_count); end
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_fetch: got %b expected 0", resp_valid); end
    endtask

    task automatic test_reset_mid();
        resp_ready  = 1'b0;
        fetch_valid = 1'b1;
        fetch_addr  = 32'h8;
        tick();
        fetch_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 16'd0;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", resp_valid); end
        n_checks++; if (resp_instr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_instr: got %h expected 0", resp_instr); end
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", fetch_count); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_ghost: got %b expected 0", resp_valid); end
        resp_ready  = 1'b1;
        fetch_valid = 1'b1;
        fetch_addr  = 32'h8;
        tick();
        fetch_valid = 1'b0;
        n_checks++; if (resp_instr !== 32'hAD29_0000) begin n_fail++; $display("FAIL rst_retained: got %h expected ad290000", resp_instr); end
        tick();
        exp_count = exp_count + 16'd1;
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL rst_count: got %0d expected %0d", fetch_count, exp_count); end
    endtask

    task automatic test_load_priority();
        resp_ready  = 1'b0;
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0;
        tick();
        fetch_addr = 32'h14;
        load_en    = 1'b1;
        load_idx   = 6'd5;
        load_data  = 32'hCAFE_F00D;
        resp_ready = 1'b1;
        #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready0: got %b expected 0", fetch_ready); end
        n_checks++; if (resp_instr !== model[0]) begin n_fail++; $display("FAIL load_hold0: got %h expected %h", resp_instr, model[0]); end
        tick();
        model[5] = 32'hCAFE_F00D;
        resp_ready = 1'b0;
        load_idx   = 6'd6;
        load_data  = 32'h0BAD_BEEF;
        #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready1: got %b expected 0", fetch_ready); end
        tick();
        model[6] = 32'h0BAD_BEEF;
        exp_count = exp_count + 16'd1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL load_consumed: got %b expected 0", resp_valid); end
        load_en    = 1'b0;
        resp_ready = 1'b1;
        #1;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready2: got %b expected 1", fetch_ready); end
        tick();
        fetch_valid = 1'b0;
        n_checks++; if (resp_instr !== model[5]) begin n_fail++; $display("FAIL load_newval: got %h expected %h", resp_instr, model[5]); end
        fetch_valid = 1'b1;
        fetch_addr  = 32'h18;
        tick();
        fetch_valid = 1'b0;
        n_checks++; if (resp_instr !== model[6]) begin n_fail++; $display("FAIL load_newval6: got %h expected %h", resp_instr, model[6]); end
        tick();
        exp_count = exp_count + 16'd2;
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL load_count: got %0d expected %0d", fetch_count, exp_count); end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_count   = 16'd0;
        rst_n       = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        resp_ready  = 1'b0;
        flush       = 1'b0;
        load_en     = 1'b0;
        load_idx    = '0;
        load_data   = '0;
        test_reset();
        for (int i = 0; i < 8; i++) begin
            do_load(6'(i), (i == 2) ? 32'hAD29_0000 : (32'h1000_0000 + 32'(i * 32'h11)));
        end
        do_load(6'd63, 32'h7777_0063);
        test_basic();
        test_streaming();
        test_backpressure();
        test_errors();
        test_flush();
        test_reset_mid();
        test_load_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
